// File: rtl/seg7_pkg.sv
// Shared 7-segment pattern constants (bit 0 = segment a ... bit 6 = segment g).
// The encoder and this decoder both take their tables from here, so the two cannot drift apart.
package seg7_pkg;

  localparam logic [6:0] SEG7_PAT_0 = 7'h3F;
  localparam logic [6:0] SEG7_PAT_1 = 7'h06;
  localparam logic [6:0] SEG7_PAT_2 = 7'h5B;
  localparam logic [6:0] SEG7_PAT_3 = 7'h4F;
  localparam logic [6:0] SEG7_PAT_4 = 7'h66;
  localparam logic [6:0] SEG7_PAT_5 = 7'h6D;
  localparam logic [6:0] SEG7_PAT_6 = 7'h7D;
  localparam logic [6:0] SEG7_PAT_7 = 7'h27;
  localparam logic [6:0] SEG7_PAT_8 = 7'h7F;
  localparam logic [6:0] SEG7_PAT_9 = 7'h6F;
  localparam logic [6:0] SEG7_PAT_A = 7'h77;
  localparam logic [6:0] SEG7_PAT_B = 7'h7C;
  localparam logic [6:0] SEG7_PAT_C = 7'h58;
  localparam logic [6:0] SEG7_PAT_D = 7'h5E;
  localparam logic [6:0] SEG7_PAT_E = 7'h79;
  localparam logic [6:0] SEG7_PAT_F = 7'h71;
  localparam logic [6:0] SEG7_BLANK = 7'h00;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex-to-7-segment table.
// nib_o is 0 unless legal_o is set; blank_o flags the all-off pattern.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic [3:0] nib_o,
  output logic       legal_o,
  output logic       blank_o
);

  always_comb begin
    nib_o   = 4'h0;
    legal_o = 1'b1;
    case (pat_i)
      SEG7_PAT_0: nib_o = 4'h0;
      SEG7_PAT_1: nib_o = 4'h1;
      SEG7_PAT_2: nib_o = 4'h2;
      SEG7_PAT_3: nib_o = 4'h3;
      SEG7_PAT_4: nib_o = 4'h4;
      SEG7_PAT_5: nib_o = 4'h5;
      SEG7_PAT_6: nib_o = 4'h6;
      SEG7_PAT_7: nib_o = 4'h7;
      SEG7_PAT_8: nib_o = 4'h8;
      SEG7_PAT_9: nib_o = 4'h9;
      SEG7_PAT_A: nib_o = 4'hA;
      SEG7_PAT_B: nib_o = 4'hB;
      SEG7_PAT_C: nib_o = 4'hC;
      SEG7_PAT_D: nib_o = 4'hD;
      SEG7_PAT_E: nib_o = 4'hE;
      SEG7_PAT_F: nib_o = 4'hF;
      default:    legal_o = 1'b0;
    endcase
  end

  assign blank_o = (pat_i == SEG7_BLANK);

endmodule

// File: rtl/seg7_scan_decoder.sv
// Readback monitor for a multiplexed 7-segment bus: captures each stable digit into a register file.
// Build option SEG7DEC_ACTIVE_LOW_EN: common-anode boards, seg_in/dig_in inverted at the input register.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   seg_in,
  input  logic [NUM_DIGITS-1:0]        dig_in,
  output logic [4*NUM_DIGITS-1:0]      digits_o,
  output logic [NUM_DIGITS-1:0]        dps_o,
  output logic [NUM_DIGITS-1:0]        valid_o,
  output logic                         upd_o,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] upd_idx_o,
  output logic                         frame_o,
  output logic                         err_o
);

  localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_HIT = CW'(STABLE_CYCLES - 1);

  logic [7:0]            seg_raw_q;
  logic [NUM_DIGITS-1:0] dig_raw_q;
  logic [7:0]            seg_s;
  logic [NUM_DIGITS-1:0] dig_s;

  // Raw pins are stored as-is so the reset value reads as idle in either polarity.
`ifdef SEG7DEC_ACTIVE_LOW_EN
  localparam logic RAW_IDLE = 1'b1;
  assign seg_s = ~seg_raw_q;
  assign dig_s = ~dig_raw_q;
`else
  localparam logic RAW_IDLE = 1'b0;
  assign seg_s = seg_raw_q;
  assign dig_s = dig_raw_q;
`endif

  logic [7:0]              seg_p_q;
  logic [NUM_DIGITS-1:0]   dig_p_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [CW-1:0]           mh_q, mh_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   dps_q, dps_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic                    upd_q, upd_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic                    frame_q, frame_d;
  logic                    err_q, err_d;

  logic            same, dig_onehot, dig_multi, capture, mh_hit;
  logic [IDXW-1:0] enc_idx;
  logic [3:0]      dec_nib;
  logic            dec_legal, dec_blank;

  seg7_pattern_decode u_dec (
    .pat_i   (seg_s[6:0]),
    .nib_o   (dec_nib),
    .legal_o (dec_legal),
    .blank_o (dec_blank)
  );

  assign same       = (seg_s == seg_p_q) && (dig_s == dig_p_q);
  assign dig_onehot = $onehot(dig_s);
  assign dig_multi  = !$onehot0(dig_s);
  assign capture    = same && dig_onehot && (cnt_q == CNT_HIT);
  assign mh_hit     = same && dig_multi && (mh_q == CNT_HIT);

  always_comb begin
    enc_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_s[i]) enc_idx = enc_idx | IDXW'(i);
    end
  end

  // Separate run counters for one-hot and multi-hot so each fires once per stable period.
  always_comb begin
    cnt_d = '0;
    mh_d  = '0;
    if (same && dig_onehot) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    if (same && dig_multi)  mh_d  = (mh_q == CNT_MAX) ? mh_q : mh_q + CW'(1);
  end

  always_comb begin
    digits_d = digits_q;
    dps_d    = dps_q;
    valid_d  = valid_q;
    mask_d   = mask_q;
    upd_d    = 1'b0;
    frame_d  = 1'b0;
    idx_d    = idx_q;
    err_d    = err_q | mh_hit;
    if (capture) begin
      upd_d = 1'b1;
      idx_d = enc_idx;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (dig_s[i]) begin
          digits_d[4*i +: 4] = dec_legal ? dec_nib : 4'h0;
          dps_d[i]           = seg_s[7];
          valid_d[i]         = dec_legal;
        end
      end
      if (!dec_legal && !dec_blank) err_d = 1'b1;
      if ((mask_q | dig_s) == {NUM_DIGITS{1'b1}}) begin
        frame_d = 1'b1;
        mask_d  = '0;
      end else begin
        mask_d = mask_q | dig_s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_raw_q <= {8{RAW_IDLE}};
      dig_raw_q <= {NUM_DIGITS{RAW_IDLE}};
      seg_p_q   <= '0;
      dig_p_q   <= '0;
      cnt_q     <= '0;
      mh_q      <= '0;
      digits_q  <= '0;
      dps_q     <= '0;
      valid_q   <= '0;
      mask_q    <= '0;
      upd_q     <= 1'b0;
      idx_q     <= '0;
      frame_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      seg_raw_q <= seg_in;
      dig_raw_q <= dig_in;
      seg_p_q   <= seg_s;
      dig_p_q   <= dig_s;
      cnt_q     <= cnt_d;
      mh_q      <= mh_d;
      digits_q  <= digits_d;
      dps_q     <= dps_d;
      valid_q   <= valid_d;
      mask_q    <= mask_d;
      upd_q     <= upd_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      err_q     <= err_d;
    end
  end

  assign digits_o  = digits_q;
  assign dps_o     = dps_q;
  assign valid_o   = valid_q;
  assign upd_o     = upd_q;
  assign upd_idx_o = idx_q;
  assign frame_o   = frame_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios plus random bus traffic, checked every cycle
// against a run-length reference model of the display bus.
module tb_seg7_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [7:0]      seg_in = 8'h00;
  logic [ND-1:0]   dig_in = '0;
  logic [4*ND-1:0] digits_o;
  logic [ND-1:0]   dps_o, valid_o;
  logic            upd_o, frame_o, err_o;
  logic [1:0]      upd_idx_o;

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .dig_in    (dig_in),
    .digits_o  (digits_o),
    .dps_o     (dps_o),
    .valid_o   (valid_o),
    .upd_o     (upd_o),
    .upd_idx_o (upd_idx_o),
    .frame_o   (frame_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_upd   = 0;
  int n_frame = 0;
  int last_upd_cyc = -1;

  logic [6:0] pats [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71};

  // Reference model: a capture happens when a sample value has been seen SC+1 times in a row.
  logic [7:0]      m_seg;
  logic [ND-1:0]   m_dig;
  int              m_run;
  logic [4*ND-1:0] m_digits;
  logic [ND-1:0]   m_dps, m_valid, m_mask;
  logic            m_upd, m_frame, m_err;
  int              m_idx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_seg = '0; m_dig = '0; m_run = 1;
    m_digits = '0; m_dps = '0; m_valid = '0; m_mask = '0;
    m_upd = 1'b0; m_frame = 1'b0; m_err = 1'b0; m_idx = 0;
  endtask

  task automatic model_step(input logic [7:0] s, input logic [ND-1:0] d, input logic r);
    int   nib;
    if (!r) begin
      model_reset();
      return;
    end
    m_upd = 1'b0;
    m_frame = 1'b0;
    if (m_run == SC + 1) begin
      if ($countones(m_dig) == 1) begin
        for (int i = 0; i < ND; i++) if (m_dig[i]) m_idx = i;
        nib = -1;
        for (int k = 0; k < 16; k++) if (pats[k] == m_seg[6:0]) nib = k;
        m_upd = 1'b1;
        m_digits[4*m_idx +: 4] = (nib >= 0) ? 4'(nib) : 4'h0;
        m_valid[m_idx] = (nib >= 0);
        m_dps[m_idx] = m_seg[7];
        if (nib < 0 && m_seg[6:0] != 7'h00) m_err = 1'b1;
        m_mask[m_idx] = 1'b1;
        if (&m_mask) begin
          m_frame = 1'b1;
          m_mask = '0;
        end
      end else if (m_dig != '0) begin
        m_err = 1'b1;
      end
    end
    if (s == m_seg && d == m_dig) begin
      if (m_run < SC + 2) m_run++;
    end else begin
      m_seg = s;
      m_dig = d;
      m_run = 1;
    end
  endtask

  task automatic compare_all();
    chk("digits", 32'(digits_o), 32'(m_digits));
    chk("dps",    32'(dps_o),    32'(m_dps));
    chk("valid",  32'(valid_o),  32'(m_valid));
    chk("upd",    32'(upd_o),    32'(m_upd));
    chk("frame",  32'(frame_o),  32'(m_frame));
    chk("err",    32'(err_o),    32'(m_err));
    if (m_upd) chk("upd_idx", 32'(upd_idx_o), 32'(m_idx));
  endtask

  task automatic run(input logic [7:0] s, input logic [ND-1:0] d, input int n, input logic r);
    for (int k = 0; k < n; k++) begin
      seg_in = s;
      dig_in = d;
      rst_n  = r;
      @(posedge clk);
      cyc++;
      model_step(s, d, r);
      #1;
      compare_all();
      if (upd_o) begin
        n_upd++;
        last_upd_cyc = cyc;
      end
      if (frame_o) n_frame++;
    end
  endtask

  initial begin
    int t0;
    logic [7:0]    rs;
    logic [ND-1:0] rd;
    int            rn, rr;

    model_reset();
    run(8'h00, 4'b0000, 2, 1'b0);
    chk("reset_outputs", {digits_o, dps_o, valid_o, upd_o, frame_o, err_o}, 32'h0);

    // single digit, capture latency and single pulse
    run(8'h00, 4'b0000, 7, 1'b1);
    n_upd = 0;
    t0 = cyc + 1;
    run(8'h06, 4'b0001, 26, 1'b1);
    chk("s1_upd_count", n_upd, 1);
    chk("s1_upd_cycle", last_upd_cyc, t0 + SC + 1);
    chk("s1_nibble0", 32'(digits_o[3:0]), 32'h1);
    chk("s1_valid", 32'(valid_o), 32'b0001);

    // full scan → frame on fourth capture
    run(8'h00, 4'b0000, 1, 1'b0);
    n_upd = 0; n_frame = 0;
    run(8'h3F, 4'b0001, 8, 1'b1);
    run(8'h5B, 4'b0010, 8, 1'b1);
    run(8'h4F, 4'b0100, 8, 1'b1);
    run(8'h66, 4'b1000, 8, 1'b1);
    chk("s2_upd_count", n_upd, 4);
    chk("s2_frame_count", n_frame, 1);
    chk("s2_digits", 32'(digits_o), 32'h4320);
    chk("s2_valid", 32'(valid_o), 32'hF);

    // illegal pattern with dp
    run(8'h85, 4'b0100, 6, 1'b1);
    run(8'h00, 4'b0000, 10, 1'b1);
    chk("s3_err", 32'(err_o), 32'h1);
    chk("s3_valid2", 32'(valid_o[2]), 32'h0);
    chk("s3_dp2", 32'(dps_o[2]), 32'h1);
    chk("s3_nibble2", 32'(digits_o[11:8]), 32'h0);

    // toggling never captures
    n_upd = 0;
    for (int k = 0; k < 6; k++) run((k % 2) ? 8'h5B : 8'h06, 4'b0010, 3, 1'b1);
    chk("s4_no_upd", n_upd, 0);
    run(8'h5B, 4'b0010, 8, 1'b1);
    chk("s4_one_upd", n_upd, 1);
    chk("s4_nibble1", 32'(digits_o[7:4]), 32'h2);

    // multi-hot and idle
    run(8'h00, 4'b0000, 1, 1'b0);
    n_upd = 0;
    run(8'h3F, 4'b0110, 10, 1'b1);
    chk("s5_err", 32'(err_o), 32'h1);
    chk("s5_no_upd", n_upd, 0);
    chk("s5_regfile", 32'({digits_o, valid_o}), 32'h0);
    run(8'h00, 4'b0000, 10, 1'b1);
    chk("s5_idle_no_upd", n_upd, 0);

    // reset mid-stable period
    run(8'h00, 4'b0000, 1, 1'b0);
    run(8'h00, 4'b0000, 3, 1'b1);
    n_upd = 0;
    run(8'h06, 4'b0001, 3, 1'b1);
    run(8'h06, 4'b0001, 1, 1'b0);
    chk("s6_rst_clear", {digits_o, dps_o, valid_o, upd_o, frame_o, err_o}, 32'h0);
    t0 = cyc + 1;
    run(8'h06, 4'b0001, 12, 1'b1);
    chk("s6_upd_count", n_upd, 1);
    chk("s6_upd_cycle", last_upd_cyc, t0 + SC + 1);

    // random bus traffic
    for (int k = 0; k < 300; k++) begin
      rr = $urandom_range(0, 99);
      if (rr < 6) rd = '0;
      else if (rr < 14) begin
        rd = ND'($urandom_range(0, 15));
        while ($countones(rd) < 2) rd = ND'($urandom_range(0, 15));
      end else rd = ND'(1 << $urandom_range(0, ND - 1));
      rr = $urandom_range(0, 99);
      if (rr < 70)      rs[6:0] = pats[$urandom_range(0, 15)];
      else if (rr < 80) rs[6:0] = 7'h00;
      else              rs[6:0] = 7'($urandom_range(0, 127));
      rs[7] = 1'($urandom_range(0, 1));
      rn = $urandom_range(1, 9);
      if ($urandom_range(0, 24) == 0) run(rs, rd, 1, 1'b0);
      run(rs, rd, rn, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
